// File: rtl/hfrv_busmux_pkg.sv
// Shared types, constants and byte-lane helpers for the HF-RISC CPU-side bus interconnect.
package hfrv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR
  } busmux_state_t;

  localparam int WAIT_W = 4;
  localparam int SEL_W  = 4;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_NONE = '1;

  // The helpers work on a generous fixed width so any DATA_W up to this can use them.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BYTES  = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] byte_swap(input logic [MAX_DATA_W-1:0] data,
                                                      input int nbytes);
    logic [MAX_DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < nbytes) r[i*8 +: 8] = data[(nbytes-1-i)*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [MAX_BYTES-1:0] lane_swap(input logic [MAX_BYTES-1:0] lanes,
                                                     input int nbytes);
    logic [MAX_BYTES-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < nbytes) r[i] = lanes[nbytes-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/hfrv_busmux_if.sv
// CPU-side and slave-side signals of the bus interconnect; 'slave' is the interconnect's view.
interface hfrv_busmux_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);

  logic [ADDR_W-1:0]            addr;
  logic [DATA_W-1:0]            wdata;
  logic [DATA_W/8-1:0]          data_we;
  logic                         ext_stall;
  logic [DATA_W-1:0]            rdata;
  logic                         stall;
  logic                         err;
  logic [ADDR_W-1:0]            err_addr;

  logic [NUM_SLAVES-1:0]        slv_cs_n;
  logic [ADDR_W-1:0]            slv_addr;
  logic [DATA_W-1:0]            slv_wdata;
  logic [DATA_W/8-1:0]          slv_we_n;
  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata;

  modport slave (
    input  addr, wdata, data_we, ext_stall, slv_rdata,
    output rdata, stall, err, err_addr, slv_cs_n, slv_addr, slv_wdata, slv_we_n
  );

  modport master (
    output addr, wdata, data_we, ext_stall, slv_rdata,
    input  rdata, stall, err, err_addr, slv_cs_n, slv_addr, slv_wdata, slv_we_n
  );

endinterface

// File: rtl/hfrv_addr_decode.sv
// Priority region decoder: matches the address MSBs against each slave's region code.
module hfrv_addr_decode
  import hfrv_bus_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int REGION_BITS = 4,
  parameter logic [NUM_SLAVES*REGION_BITS-1:0] SLV_REGION = {4'he, 4'h4, 4'h0, 4'h2}
) (
  input  logic [REGION_BITS-1:0] region,
  output logic                   hit,
  output sel_t                   idx
);

  // Region entry 0 is the leftmost field; scanning downwards lets the lowest index win.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_SLAVES-1; k >= 0; k--) begin
      if (region == SLV_REGION[(NUM_SLAVES-1-k)*REGION_BITS +: REGION_BITS]) begin
        hit = 1'b1;
        idx = sel_t'(k);
      end
    end
  end

endmodule

// File: rtl/hfrv_busmux.sv
// CPU-side bus interconnect: N decoded slave regions with wait states, byte-lane swap,
// CPU stall generation, registered read return and bus-error reporting for unmapped addresses.
module hfrv_busmux
  import hfrv_bus_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int REGION_BITS = 4,
  parameter logic [NUM_SLAVES*REGION_BITS-1:0] SLV_REGION = {4'he, 4'h4, 4'h0, 4'h2},
  parameter logic [NUM_SLAVES*WAIT_W-1:0]      SLV_WAIT   = {4'd0, 4'd0, 4'd0, 4'd3},
  parameter logic [NUM_SLAVES-1:0]             SLV_SWAP   = 4'b0001,
  parameter logic [DATA_W-1:0]                 DEFAULT_RDATA = '0
) (
  input logic          clk_i,
  input logic          rst_n_i,
  hfrv_busmux_if.slave bus
);

  localparam int NBYTES = DATA_W / 8;

  function automatic logic [DATA_W-1:0] swap_data(input logic [DATA_W-1:0] d);
    logic [MAX_DATA_W-1:0] w;
    w = byte_swap(MAX_DATA_W'(d), NBYTES);
    return w[DATA_W-1:0];
  endfunction

  function automatic logic [NBYTES-1:0] swap_lanes(input logic [NBYTES-1:0] l);
    logic [MAX_BYTES-1:0] w;
    w = lane_swap(MAX_BYTES'(l), NBYTES);
    return w[NBYTES-1:0];
  endfunction

  // Wait entries follow the same leftmost-is-slave-0 ordering as the region codes.
  function automatic logic [WAIT_W-1:0] wait_of(input sel_t s);
    logic [WAIT_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (s == sel_t'(k)) r = SLV_WAIT[(NUM_SLAVES-1-k)*WAIT_W +: WAIT_W];
    end
    return r;
  endfunction

  function automatic logic swap_of(input sel_t s);
    logic r;
    r = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (s == sel_t'(k)) r = SLV_SWAP[k];
    end
    return r;
  endfunction

  busmux_state_t       state_q, state_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
  logic [NBYTES-1:0]   lat_we_n_q, lat_we_n_d;
  sel_t                lat_sel_q, lat_sel_d;
  sel_t                rd_sel_q, rd_sel_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

  logic                hit;
  sel_t                hit_idx;
  logic [WAIT_W-1:0]   hit_wait;
  logic                hit_swap;
  logic                access_valid;
  logic [DATA_W-1:0]   in_wdata;
  logic [NBYTES-1:0]   in_we_n;

  sel_t                cs_sel;
  logic                stall;
  logic [ADDR_W-1:0]   slv_addr;
  logic [DATA_W-1:0]   slv_wdata;
  logic [NBYTES-1:0]   slv_we_n;

  logic [DATA_W-1:0]   rd_raw;
  logic                rd_swap;

  hfrv_addr_decode #(
    .NUM_SLAVES  (NUM_SLAVES),
    .REGION_BITS (REGION_BITS),
    .SLV_REGION  (SLV_REGION)
  ) u_decode (
    .region (bus.addr[ADDR_W-1 -: REGION_BITS]),
    .hit    (hit),
    .idx    (hit_idx)
  );

  assign hit_wait = wait_of(hit_idx);
  assign hit_swap = swap_of(hit_idx);
  assign in_wdata = hit_swap ? swap_data(bus.wdata) : bus.wdata;
  assign in_we_n  = ~(hit_swap ? swap_lanes(bus.data_we) : bus.data_we);

  // Gating with rst_n_i keeps cs/stall released the moment reset is applied.
  assign access_valid = rst_n_i && !bus.ext_stall && (state_q == IDLE);

  // The accepting cycle already counts as the first stall cycle, so WAIT holds W-1 more
  // stall cycles plus one final cs-low cycle in which the write actually commits.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_we_n_d  = lat_we_n_q;
    lat_sel_d   = lat_sel_q;
    rd_sel_d    = SEL_NONE;
    err_d       = 1'b0;
    err_addr_d  = err_addr_q;
    cs_sel      = SEL_NONE;
    stall       = 1'b0;
    slv_addr    = bus.addr;
    slv_wdata   = bus.wdata;
    slv_we_n    = '1;

    case (state_q)
      IDLE: begin
        if (access_valid) begin
          if (!hit) begin
            err_d      = 1'b1;
            err_addr_d = bus.addr;
            state_d    = ERR;
          end else begin
            cs_sel    = hit_idx;
            slv_wdata = in_wdata;
            if (hit_wait == '0) begin
              slv_we_n = in_we_n;
              rd_sel_d = hit_idx;
            end else begin
              stall       = 1'b1;
              wcnt_d      = hit_wait - WAIT_W'(1);
              lat_addr_d  = bus.addr;
              lat_wdata_d = in_wdata;
              lat_we_n_d  = in_we_n;
              lat_sel_d   = hit_idx;
              state_d     = WAIT;
            end
          end
        end
      end

      WAIT: begin
        cs_sel    = lat_sel_q;
        slv_addr  = lat_addr_q;
        slv_wdata = lat_wdata_q;
        if (wcnt_q != '0) begin
          stall  = 1'b1;
          wcnt_d = wcnt_q - WAIT_W'(1);
        end else begin
          slv_we_n = lat_we_n_q;
          rd_sel_d = lat_sel_q;
          state_d  = IDLE;
        end
      end

      ERR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_we_n_q  <= '1;
      lat_sel_q   <= SEL_NONE;
      rd_sel_q    <= SEL_NONE;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_we_n_q  <= lat_we_n_d;
      lat_sel_q   <= lat_sel_d;
      rd_sel_q    <= rd_sel_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  always_comb begin
    bus.slv_cs_n = '1;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (cs_sel == sel_t'(k)) bus.slv_cs_n[k] = 1'b0;
    end
  end

  // Read data comes back one cycle after the final cs-low cycle, from the slave it addressed.
  always_comb begin
    rd_raw  = '0;
    rd_swap = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (rd_sel_q == sel_t'(k)) begin
        rd_raw  = bus.slv_rdata[k*DATA_W +: DATA_W];
        rd_swap = SLV_SWAP[k];
      end
    end
  end

  assign bus.rdata     = (rd_sel_q == SEL_NONE) ? DEFAULT_RDATA
                                                : (rd_swap ? swap_data(rd_raw) : rd_raw);
  assign bus.stall     = stall;
  assign bus.err       = err_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.slv_addr  = slv_addr;
  assign bus.slv_wdata = slv_wdata;
  assign bus.slv_we_n  = slv_we_n;

endmodule

// File: tb/tb_hfrv_busmux.sv
// Directed bench for hfrv_busmux: read expectations go through a scoreboard queue and are
// popped the cycle the registered read data is due; slave writes are logged by a monitor.
`timescale 1ns/1ps
module tb_hfrv_busmux;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q [$];
  int          wr_count [NS] = '{default: 0};
  logic [31:0] wr_data [NS];
  int          stall_cnt;
  int          cs_cnt;
  int          n;

  hfrv_busmux_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  hfrv_busmux dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // A write lands at a slave when its cs and any byte enable are low together.
  always @(negedge clk) begin
    for (int k = 0; k < NS; k++) begin
      if (rst_n && !bus.slv_cs_n[k] && bus.slv_we_n != 4'hF) begin
        wr_count[k] = wr_count[k] + 1;
        wr_data[k]  = bus.slv_wdata;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRead(input string tag);
    logic [31:0] e;
    e = 32'bx;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    checkOutput(tag, 64'(bus.rdata), 64'(e));
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] we, input logic st);
    bus.addr      = a;
    bus.wdata     = d;
    bus.data_we   = we;
    bus.ext_stall = st;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.slv_rdata = {32'hCAFE_F00D, 32'h0102_0304, 32'hAABB_CCDD, 32'h4433_2211};
    applyStimulus(32'h4000_0010, 32'h0, 4'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall",    64'(bus.stall),    64'(0));
    checkOutput("rst_err",      64'(bus.err),      64'(0));
    checkOutput("rst_err_addr", 64'(bus.err_addr), 64'(0));
    checkOutput("rst_rdata",    64'(bus.rdata),    64'(0));
    checkOutput("rst_cs_n",     64'(bus.slv_cs_n), 64'hF);
    checkOutput("rst_we_n",     64'(bus.slv_we_n), 64'hF);

    nextCycle();
    rst_n = 1'b1;
    applyStimulus(32'h0, 32'h0, 4'h0, 1'b1);

    $display("[TB] zero-wait read from slave1");
    nextCycle();
    applyStimulus(32'h4000_0010, 32'h0, 4'h0, 1'b0);
    exp_q.push_back(32'hAABB_CCDD);
    @(negedge clk);
    checkOutput("s1_cs_n",  64'(bus.slv_cs_n), 64'hD);
    checkOutput("s1_stall", 64'(bus.stall),    64'(0));
    nextCycle();
    applyStimulus(32'h0, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("s1_cs_release", 64'(bus.slv_cs_n), 64'hF);
    checkRead("s1_rdata");

    $display("[TB] swapped write and back-to-back reads");
    nextCycle();
    applyStimulus(32'hE000_0000, 32'h1122_3344, 4'hF, 1'b0);
    @(negedge clk);
    checkOutput("s0_wr_cs_n",  64'(bus.slv_cs_n),  64'hE);
    checkOutput("s0_wr_data",  64'(bus.slv_wdata), 64'h4433_2211);
    checkOutput("s0_wr_we_n",  64'(bus.slv_we_n),  64'h0);
    nextCycle();
    applyStimulus(32'hE000_0004, 32'h0, 4'h0, 1'b0);
    exp_q.push_back(32'h1122_3344);
    @(negedge clk);
    checkOutput("s0_rd_we_n", 64'(bus.slv_we_n), 64'hF);
    nextCycle();
    applyStimulus(32'h0000_0100, 32'h0, 4'h0, 1'b0);
    exp_q.push_back(32'h0102_0304);
    @(negedge clk);
    checkOutput("s2_cs_n", 64'(bus.slv_cs_n), 64'hB);
    checkRead("s0_rdata_swap");

    $display("[TB] waited read from slave3 right after a zero-wait read");
    nextCycle();
    applyStimulus(32'h2000_0000, 32'h0, 4'h0, 1'b0);
    exp_q.push_back(32'hCAFE_F00D);
    @(negedge clk);
    checkRead("s2_rdata_in_stall");
    checkOutput("s3_first_stall", 64'(bus.stall),    64'(1));
    checkOutput("s3_first_cs_n",  64'(bus.slv_cs_n), 64'h7);
    stall_cnt = 1;
    cs_cnt    = 1;
    n         = 0;
    do begin
      nextCycle();
      if (n == 0) applyStimulus(32'h4000_0000, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      if (!bus.slv_cs_n[3]) cs_cnt++;
      if (bus.stall) stall_cnt++;
      n++;
    end while (bus.stall && n < 8);
    checkOutput("s3_stall_cycles", 64'(stall_cnt),    64'(3));
    checkOutput("s3_cs_cycles",    64'(cs_cnt),       64'(4));
    checkOutput("s3_held_addr",    64'(bus.slv_addr), 64'h2000_0000);
    nextCycle();
    applyStimulus(32'h0, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("s3_cs_release", 64'(bus.slv_cs_n), 64'hF);
    checkRead("s3_rdata");
    checkOutput("s0_wr_count",  64'(wr_count[0]), 64'(1));
    checkOutput("s0_wr_logged", 64'(wr_data[0]),  64'h4433_2211);

    $display("[TB] reset during a waited write");
    nextCycle();
    applyStimulus(32'h2000_0008, 32'h5555_AAAA, 4'hF, 1'b0);
    @(negedge clk);
    checkOutput("s3_wr_stall",      64'(bus.stall),    64'(1));
    checkOutput("s3_wr_early_we_n", 64'(bus.slv_we_n), 64'hF);
    nextCycle();
    nextCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("midwait_rst_stall", 64'(bus.stall),    64'(0));
    checkOutput("midwait_rst_cs_n",  64'(bus.slv_cs_n), 64'hF);
    checkOutput("midwait_rst_we_n",  64'(bus.slv_we_n), 64'hF);
    applyStimulus(32'h0, 32'h0, 4'h0, 1'b1);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midwait_no_write", 64'(wr_count[3]), 64'(0));
    checkOutput("post_rst_rdata",   64'(bus.rdata),   64'(0));

    $display("[TB] unmapped access");
    nextCycle();
    applyStimulus(32'h8000_0000, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("unmapped_cs_n",      64'(bus.slv_cs_n), 64'hF);
    checkOutput("unmapped_err_early", 64'(bus.err),      64'(0));
    checkOutput("unmapped_we_n",      64'(bus.slv_we_n), 64'hF);
    nextCycle();
    applyStimulus(32'h4000_0010, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("err_pulse",     64'(bus.err),      64'(1));
    checkOutput("err_addr",      64'(bus.err_addr), 64'h8000_0000);
    checkOutput("err_no_accept", 64'(bus.slv_cs_n), 64'hF);
    checkOutput("err_rdata",     64'(bus.rdata),    64'(0));
    nextCycle();
    applyStimulus(32'h0, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("err_one_cycle",  64'(bus.err),      64'(0));
    checkOutput("err_addr_held",  64'(bus.err_addr), 64'h8000_0000);
    checkOutput("err_after_rdata", 64'(bus.rdata),   64'(0));

    $display("[TB] external stall holds off an access");
    nextCycle();
    applyStimulus(32'h4000_0020, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("ext_stall_cs_n",  64'(bus.slv_cs_n), 64'hF);
    checkOutput("ext_stall_stall", 64'(bus.stall),    64'(0));
    nextCycle();
    @(negedge clk);
    checkOutput("ext_stall_cs_n2", 64'(bus.slv_cs_n), 64'hF);
    nextCycle();
    applyStimulus(32'h4000_0020, 32'h0, 4'h0, 1'b0);
    exp_q.push_back(32'hAABB_CCDD);
    @(negedge clk);
    checkOutput("ext_release_cs_n", 64'(bus.slv_cs_n), 64'hD);
    nextCycle();
    applyStimulus(32'h0, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    checkRead("ext_release_rdata");

    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
